// File: rtl/word16_serial_tx_pkg.sv
// Shared definitions for the 16-bit word serial link: FSM encodings, line levels, parity sense.
package word16_serial_tx_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_BIT_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // 1 = odd parity (ones in data+parity is odd), 0 = even
  localparam logic PARITY_ODD = 1'b1;

  // Counter width that stays legal for a terminal count of 1
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word16_serial_tx_timer.sv
// Bit-period timer: tick on the last cycle of every BIT_DIV-cycle bit, tick_pre one cycle earlier.
module serial_bit_timer
  import word16_serial_tx_pkg::*;
#(
  parameter int unsigned BIT_DIV = DEF_BIT_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run,
  output logic tick,
  output logic tick_pre
);

  localparam int unsigned CW = cnt_width(BIT_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = (BIT_DIV > 1) ? CW'(BIT_DIV - 2) : '0;

  logic [CW-1:0] r_cnt;

  // Restart whenever idle so every frame begins on a fresh bit period
  always_ff @(posedge clk_i) begin
    if (rst_i || !run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick     = run && (r_cnt == CNT_LAST);
  assign tick_pre = (BIT_DIV > 1) && run && (r_cnt == CNT_PRE);

endmodule

// File: rtl/word16_serial_tx.sv
// Serial word transmitter: accepts a word on valid/ready and sends start, data MSB first, parity, stop.
module word16_serial_tx
  import word16_serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned BIT_DIV = DEF_BIT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [BW-1:0]    r_bitcnt;
  logic [BW-1:0]    w_bitcnt_next;
  logic             r_parity;
  logic             w_parity_next;
  logic             r_tx;
  logic             w_tx_next;
  logic             r_busy;
  logic             r_done;
  logic             w_done_next;
  logic             w_run;
  logic             w_tick;
  logic             w_tick_pre;
  logic             w_accept;

  assign w_run    = (r_state != ST_IDLE);
  assign ready_o  = (r_state == ST_IDLE) && !rst_i;
  assign w_accept = valid_i && ready_o;

  serial_bit_timer #(
    .BIT_DIV(BIT_DIV)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run     (w_run),
    .tick    (w_tick),
    .tick_pre(w_tick_pre)
  );

  // Next state, shifter and bit counter
  always_comb begin
    w_state_next  = r_state;
    w_shreg_next  = r_shreg;
    w_bitcnt_next = r_bitcnt;
    w_parity_next = r_parity;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next  = ST_START;
          w_shreg_next  = dat_i;
          w_bitcnt_next = '0;
          w_parity_next = PARITY_ODD ? ~^dat_i : ^dat_i;
        end
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bitcnt == BIT_LAST) begin
            w_state_next  = ST_PARITY;
            w_bitcnt_next = '0;
          end else begin
            w_bitcnt_next = r_bitcnt + BW'(1);
            w_shreg_next  = {r_shreg[WIDTH-2:0], 1'b0};
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Line level and done pulse are computed one cycle ahead so both leave flops
  always_comb begin
    w_tx_next = LINE_IDLE;
    case (w_state_next)
      ST_START:  w_tx_next = LINE_START;
      ST_DATA:   w_tx_next = w_shreg_next[WIDTH-1];
      ST_PARITY: w_tx_next = w_parity_next;
      ST_STOP:   w_tx_next = LINE_STOP;
      default:   w_tx_next = LINE_IDLE;
    endcase
    if (BIT_DIV == 1) begin
      w_done_next = (r_state == ST_PARITY) && w_tick;
    end else begin
      w_done_next = (r_state == ST_STOP) && w_tick_pre;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_parity <= 1'b0;
      r_tx     <= LINE_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shreg  <= w_shreg_next;
      r_bitcnt <= w_bitcnt_next;
      r_parity <= w_parity_next;
      r_tx     <= w_tx_next;
      r_busy   <= (w_state_next != ST_IDLE);
      r_done   <= w_done_next;
    end
  end

  assign tx_o         = r_tx;
  assign busy_o       = r_busy;
  assign frame_done_o = r_done;

endmodule

// File: tb/tb_word16_serial_tx.sv
// Bench for word16_serial_tx: three instances (BIT_DIV 4/1/3), deserializer model and scoreboard.
module tb_word16_serial_tx;

  localparam int W  = 16;
  localparam int NI = 3;

  function automatic int unsigned div_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  typedef struct {
    int           inst;
    logic [W-1:0] word;
    logic         par;
  } vec_t;

  logic          clk = 1'b0;
  logic [NI-1:0] rst;
  logic [NI-1:0] valid;
  logic [NI-1:0] ready;
  logic [NI-1:0] tx;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;
  logic [W-1:0]  dat [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    word16_serial_tx #(
      .WIDTH  (W),
      .BIT_DIV(div_of(g))
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .dat_i       (dat[g]),
      .valid_i     (valid[g]),
      .ready_o     (ready[g]),
      .tx_o        (tx[g]),
      .busy_o      (busy[g]),
      .frame_done_o(done[g])
    );
  end

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  bit           acc       [NI];
  int           acc_cyc   [NI];
  bit           rst_pre   [NI];
  bit           infrm     [NI];
  int           bcyc      [NI];
  logic [W+2:0] fbits     [NI];
  int           last_start[NI];
  int           last_gap  [NI];
  int           prev_gap  [NI];
  int           nstarts   [NI];
  int           rx_cnt    [NI];
  int           done_cnt  [NI];
  logic [W-1:0] rx_word   [NI];
  logic         rx_par    [NI];
  logic [255:0] tx_hist   [NI];

  task automatic check(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] w);
    case (i)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic pop(input int i, output logic [W-1:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    case (i)
      0:       if (q0.size() > 0) begin w = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin w = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin w = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Deserializer model: samples mid-bit, checks framing/parity/done, scores words
  task automatic monitor(input int i);
    int           d;
    int           f;
    logic [W-1:0] w;
    logic [W-1:0] e;
    bit           ok;
    d = int'(div_of(i));
    f = (W + 3) * d;
    tx_hist[i] = {tx_hist[i][254:0], tx[i]};
    if (done[i] === 1'b1) done_cnt[i]++;
    if (rst_pre[i]) begin
      check("rst_tx", i, 128'(tx[i]), 128'(1));
      check("rst_busy", i, 128'(busy[i]), 128'(0));
      check("rst_done", i, 128'(done[i]), 128'(0));
      if (infrm[i]) begin
        pop(i, w, ok);
        infrm[i] = 1'b0;
      end
      return;
    end
    if (busy[i] === 1'b0) check("idle_line", i, 128'(tx[i]), 128'(1));
    if (!infrm[i]) begin
      if (tx[i] === 1'b0) begin
        infrm[i] = 1'b1;
        bcyc[i]  = 0;
        if (nstarts[i] > 0) begin
          prev_gap[i] = last_gap[i];
          last_gap[i] = cyc - last_start[i];
        end
        last_start[i] = cyc;
        nstarts[i]++;
      end
    end else begin
      bcyc[i]++;
    end
    check("frame_done", i, 128'(done[i]), 128'(infrm[i] && (bcyc[i] == f - 1)));
    if (infrm[i]) begin
      if ((bcyc[i] % d) == (d / 2)) fbits[i][bcyc[i] / d] = tx[i];
      if (bcyc[i] == f - 1) begin
        for (int j = 0; j < W; j++) w[W-1-j] = fbits[i][1+j];
        rx_word[i] = w;
        rx_par[i]  = fbits[i][W+1];
        rx_cnt[i]++;
        infrm[i] = 1'b0;
        check("start_bit", i, 128'(fbits[i][0]), 128'(0));
        check("stop_bit", i, 128'(fbits[i][W+2]), 128'(1));
        check("parity", i, 128'(rx_par[i]), 128'(~^w));
        pop(i, e, ok);
        check("sb_nonempty", i, 128'(ok), 128'(1));
        if (ok) check("sb_word", i, 128'(w), 128'(e));
      end
    end
  endtask

  // One clock: score accepts just before the edge, then observe at the falling edge
  task automatic cycle();
    #1;
    for (int i = 0; i < NI; i++) begin
      rst_pre[i] = rst[i];
      acc[i]     = 1'b0;
      if (valid[i] === 1'b1 && ready[i] === 1'b1) begin
        acc[i]     = 1'b1;
        acc_cyc[i] = cyc;
        push(i, dat[i]);
      end
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) monitor(i);
  endtask

  task automatic run_until(input int c);
    while (cyc < c) cycle();
  endtask

  task automatic wait_rx(input int i, input int target);
    int n;
    n = 0;
    while (rx_cnt[i] < target && n < 3000) begin
      cycle();
      n++;
    end
    check("rx_count", i, 128'(rx_cnt[i]), 128'(target));
  endtask

  task automatic send(input int i, input logic [W-1:0] w);
    int n;
    n = 0;
    valid[i] = 1'b1;
    dat[i]   = w;
    do begin
      cycle();
      n++;
    end while (!acc[i] && n < 400);
    valid[i] = 1'b0;
    dat[i]   = W'($urandom);
    check("accept", i, 128'(acc[i]), 128'(1));
  endtask

  task automatic burst(input int i, input int nw, input logic [W-1:0] w0, input logic [W-1:0] w1,
                       input logic [W-1:0] w2);
    logic [W-1:0] ws [3];
    int           idx;
    int           n;
    int           base;
    ws[0] = w0;
    ws[1] = w1;
    ws[2] = w2;
    base  = rx_cnt[i];
    idx   = 0;
    n     = 0;
    valid[i] = 1'b1;
    dat[i]   = ws[0];
    while (idx < nw && n < 2000) begin
      cycle();
      n++;
      if (acc[i]) idx++;
      if (idx >= nw) valid[i] = 1'b0;
      dat[i] = (ready[i] === 1'b1 && idx < nw) ? ws[idx] : W'($urandom);
    end
    check("burst_accepts", i, 128'(idx), 128'(nw));
    wait_rx(i, base + nw);
  endtask

  initial begin
    vec_t         tbl [9];
    logic [W-1:0] a5 = 16'hA5C3;
    logic [75:0]  exp_w;
    logic [75:0]  act_w;
    int           n;
    int           b;
    int           d0;
    int           base [NI];
    int           sent [NI];
    int           gap  [NI];
    bit           busy_any;

    tbl[0] = '{0, 16'hA5C3, 1'b1};
    tbl[1] = '{0, 16'h0001, 1'b0};
    tbl[2] = '{1, 16'hFFFF, 1'b1};
    tbl[3] = '{1, 16'h8000, 1'b0};
    tbl[4] = '{2, 16'h7FFF, 1'b0};
    tbl[5] = '{2, 16'h1234, 1'b0};
    tbl[6] = '{0, 16'h0000, 1'b1};
    tbl[7] = '{2, 16'h0F0F, 1'b1};
    tbl[8] = '{1, 16'h0003, 1'b1};

    for (int i = 0; i < NI; i++) begin
      dat[i] = '0;
      infrm[i] = 1'b0;
      bcyc[i] = 0;
      fbits[i] = '0;
      last_start[i] = 0;
      last_gap[i] = 0;
      prev_gap[i] = 0;
      nstarts[i] = 0;
      rx_cnt[i] = 0;
      done_cnt[i] = 0;
      rx_word[i] = '0;
      rx_par[i] = 1'b0;
      tx_hist[i] = '1;
      acc[i] = 1'b0;
      acc_cyc[i] = 0;
      rst_pre[i] = 1'b0;
    end
    rst   = '1;
    valid = '0;

    // Reset: line idle, not busy, not ready while held
    repeat (3) cycle();
    for (int i = 0; i < NI; i++) check("ready_in_reset", i, 128'(ready[i]), 128'(0));
    rst = '0;
    #1;
    for (int i = 0; i < NI; i++) check("ready_after_reset", i, 128'(ready[i]), 128'(1));

    // A5C3 at 4 cycles/bit: exact waveform, done at +76, ready back at +77
    send(0, a5);
    b = acc_cyc[0];
    check("first_start_bit", 0, 128'(tx[0]), 128'(0));
    run_until(b + 75);
    check("done_before_last", 0, 128'(done[0]), 128'(0));
    cycle();
    check("done_at_76", 0, 128'(done[0]), 128'(1));
    check("ready_at_76", 0, 128'(ready[0]), 128'(0));
    cycle();
    check("done_at_77", 0, 128'(done[0]), 128'(0));
    check("ready_at_77", 0, 128'(ready[0]), 128'(1));
    for (int t = 1; t <= 76; t++) begin
      n = (t - 1) / 4;
      if (n == 0)       exp_w[t-1] = 1'b0;
      else if (n <= W)  exp_w[t-1] = a5[W-n];
      else              exp_w[t-1] = 1'b1;
      act_w[t-1] = tx_hist[0][77-t];
    end
    check("a5c3_wave", 0, 128'(act_w), 128'(exp_w));

    // Table of words with hand-derived parity bits
    for (int k = 0; k < 9; k++) begin
      n = rx_cnt[tbl[k].inst];
      send(tbl[k].inst, tbl[k].word);
      wait_rx(tbl[k].inst, n + 1);
      check("tbl_word", tbl[k].inst, 128'(rx_word[tbl[k].inst]), 128'(tbl[k].word));
      check("tbl_parity", tbl[k].inst, 128'(rx_par[tbl[k].inst]), 128'(tbl[k].par));
    end

    // valid held high with 1,2,3: start bits 77 apart, dat junk while busy
    burst(0, 3, 16'd1, 16'd2, 16'd3);
    check("b2b_gap1", 0, 128'(prev_gap[0]), 128'(77));
    check("b2b_gap2", 0, 128'(last_gap[0]), 128'(77));
    check("b2b_last", 0, 128'(rx_word[0]), 128'(16'd3));

    // Reset pulse during the 7th data bit aborts cleanly
    d0 = done_cnt[0];
    n  = rx_cnt[0];
    send(0, 16'h5A3C);
    b = acc_cyc[0];
    run_until(b + 30);
    rst[0] = 1'b1;
    cycle();
    rst[0] = 1'b0;
    repeat (100) cycle();
    check("abort_no_done", 0, 128'(done_cnt[0]), 128'(d0));
    check("abort_no_rx", 0, 128'(rx_cnt[0]), 128'(n));
    send(0, 16'hC0DE);
    wait_rx(0, n + 1);
    check("after_abort_word", 0, 128'(rx_word[0]), 128'(16'hC0DE));
    check("after_abort_done", 0, 128'(done_cnt[0]), 128'(d0 + 1));

    // BIT_DIV=1: 19-cycle frame, done at +19, back-to-back 20 apart
    send(1, 16'hBEEF);
    b = acc_cyc[1];
    run_until(b + 18);
    check("div1_done_18", 1, 128'(done[1]), 128'(0));
    cycle();
    check("div1_done_19", 1, 128'(done[1]), 128'(1));
    cycle();
    check("div1_done_20", 1, 128'(done[1]), 128'(0));
    check("div1_ready_20", 1, 128'(ready[1]), 128'(1));
    burst(1, 2, 16'h1111, 16'h2222, 16'h0000);
    check("div1_gap", 1, 128'(last_gap[1]), 128'(20));

    // Random words and valid gaps on all three dividers
    for (int i = 0; i < NI; i++) begin
      base[i] = rx_cnt[i];
      sent[i] = 0;
      gap[i]  = 0;
    end
    n = 0;
    while ((sent[0] < 334 || sent[1] < 333 || sent[2] < 333) && n < 60000) begin
      cycle();
      n++;
      for (int i = 0; i < NI; i++) begin
        if (acc[i]) begin
          sent[i]++;
          valid[i] = 1'b0;
          gap[i]   = $urandom_range(0, 4);
        end else if (!valid[i] && sent[i] < ((i == 0) ? 334 : 333)) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            valid[i] = 1'b1;
            dat[i]   = W'($urandom);
          end
        end
        if (!valid[i]) dat[i] = W'($urandom);
      end
    end
    valid = '0;
    for (int i = 0; i < NI; i++) begin
      check("rand_sent", i, 128'(sent[i]), 128'((i == 0) ? 334 : 333));
      wait_rx(i, base[i] + sent[i]);
      check("sb_drained", i, 128'(qsize(i)), 128'(0));
    end
    repeat (5) cycle();
    busy_any = |busy;
    check("all_idle", 0, 128'(busy_any), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
